// File: rtl/lut_mult_sequencer.sv
// Sequential unsigned multiplier: consumes the multiplier two bits per cycle through a
// 0/A/2A/3A lookup, accumulates the shifted partials, and stops early on a zero tail.
module lut_mult_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGIT_BITS = 2
) (
  input  logic                                        Clock,
  input  logic                                        Reset,
  input  logic                                        iStart,
  input  logic [DATA_WIDTH-1:0]                       iData_A,
  input  logic [DATA_WIDTH-1:0]                       iData_B,
  input  logic                                        iAck,
  output logic                                        oBusy,
  output logic                                        oValid,
  output logic [2*DATA_WIDTH-1:0]                     oResult,
  output logic [$clog2(DATA_WIDTH/DIGIT_BITS)-1:0]    oStep
);

  localparam int RES_W  = 2 * DATA_WIDTH;
  localparam int STEPS  = DATA_WIDTH / DIGIT_BITS;
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [RES_W-1:0]      a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [RES_W-1:0]      acc;
  logic [STEP_W-1:0]     cnt;
  logic                  load;
  logic                  last_step;

  function automatic logic [RES_W-1:0] partial(input logic [RES_W-1:0] a,
                                                input logic [1:0]       d);
    logic [RES_W-1:0] a2;
    a2 = a << 1;
    case (d)
      2'd0:    partial = '0;
      2'd1:    partial = a;
      2'd2:    partial = a2;
      default: partial = a2 + a;
    endcase
  endfunction

  // Stop as soon as no nonzero digits remain above the one being consumed now.
  assign last_step = ((b_sh >> DIGIT_BITS) == '0) || (cnt == STEP_W'(STEPS - 1));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (iAck) begin
          if (iStart) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= {{DATA_WIDTH{1'b0}}, iData_A};
      b_sh <= iData_B;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc + partial(a_sh, b_sh[DIGIT_BITS-1:0]);
      a_sh <= a_sh << DIGIT_BITS;
      b_sh <= b_sh >> DIGIT_BITS;
      cnt  <= cnt + 1'b1;
    end
  end

  assign oBusy   = (state != IDLE);
  assign oValid  = (state == DONE);
  assign oResult = acc;
  assign oStep   = (state == RUN) ? cnt : '0;

endmodule
